// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: operation request, result response and busy status.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, funct3, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, funct3, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_unit.sv
// RV M-extension multiply/divide unit: fixed-latency multiply and radix-2 restoring divide.
// The divider is only built when the MULDIV_DIV_EN macro is defined.
module muldiv_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MUL_LATENCY = 3
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned CntW = $clog2(XLEN + 1);
  localparam logic [CntW-1:0] MulLast = CntW'((MUL_LATENCY > 1) ? MUL_LATENCY - 2 : 0);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [XLEN-1:0] res_q;
  logic            out_valid_q;

  // op[1:0]: 00 MUL (low half), 01 MULH, 10 MULHSU, 11 MULHU (high halves).
  function automatic logic [XLEN-1:0] mul_op(input logic [1:0] op, input logic [XLEN-1:0] x,
                                             input logic [XLEN-1:0] y);
    logic [2*XLEN-1:0] xe;
    logic [2*XLEN-1:0] ye;
    logic [2*XLEN-1:0] p;
    xe = ((op == 2'b01 || op == 2'b10) && x[XLEN-1]) ? {{XLEN{1'b1}}, x} : {{XLEN{1'b0}}, x};
    ye = (op == 2'b01 && y[XLEN-1]) ? {{XLEN{1'b1}}, y} : {{XLEN{1'b0}}, y};
    p  = xe * ye;
    return (op == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0] rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;

  logic            is_signed;
  logic            neg_a;
  logic            neg_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            b_zero;
  logic            ovf;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  always_comb begin
    is_signed = ~bus.funct3[0];
    neg_a     = is_signed & bus.a[XLEN-1];
    neg_b     = is_signed & bus.b[XLEN-1];
    mag_a     = neg_a ? -bus.a : bus.a;
    mag_b     = neg_b ? -bus.b : bus.b;
    b_zero    = (bus.b == '0);
    ovf       = is_signed && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
    // Quotient shifts through a_q; remainder accumulates in rem_q.
    rem_sh    = {rem_q, a_q[XLEN-1]};
    diff      = rem_sh - {1'b0, b_q};
    rem_nx    = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_nx    = {a_q[XLEN-2:0], ~diff[XLEN]};
    quo_fix   = neg_quo_q ? -a_q : a_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            op_q  <= bus.funct3[1:0];
            cnt_q <= '0;
            if (!bus.funct3[2]) begin
              a_q <= bus.a;
              b_q <= bus.b;
              if (MUL_LATENCY == 1) begin
                res_q       <= mul_op(bus.funct3[1:0], bus.a, bus.b);
                out_valid_q <= 1'b1;
                state_q     <= StDone;
              end else begin
                state_q <= StMul;
              end
            end else begin
`ifdef MULDIV_DIV_EN
              if (b_zero) begin
                res_q       <= bus.funct3[1] ? bus.a : '1;
                out_valid_q <= 1'b1;
                state_q     <= StDone;
              end else if (ovf) begin
                res_q       <= bus.funct3[1] ? '0 : bus.a;
                out_valid_q <= 1'b1;
                state_q     <= StDone;
              end else begin
                a_q       <= mag_a;
                b_q       <= mag_b;
                rem_q     <= '0;
                neg_quo_q <= neg_a ^ neg_b;
                neg_rem_q <= neg_a;
                state_q   <= StDiv;
              end
`else
              res_q       <= '0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
`endif
            end
          end
        end
        StMul: begin
          if (cnt_q == MulLast) begin
            res_q       <= mul_op(op_q, a_q, b_q);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDiv: begin
`ifdef MULDIV_DIV_EN
          // XLEN iterations, then one cycle for sign fix-up.
          if (cnt_q == CntW'(XLEN)) begin
            res_q       <= op_q[1] ? rem_fix : quo_fix;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            rem_q <= rem_nx;
            a_q   <= quo_nx;
            cnt_q <= cnt_q + 1'b1;
          end
`else
          state_q <= StIdle;
`endif
        end
        StDone: begin
          if (bus.out_ready) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; legal values 32 and 64.
REQ-002 Parameter MUL_LATENCY, default 3: cycles from input acceptance to out_valid for multiply ops; legal range 1..6.
REQ-003 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 Port in_valid, input, 1: operation request valid.
REQ-006 Port in_ready, output, 1: unit can accept a request.
REQ-007 Port funct3, input, 3: RV M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 Port a, input, XLEN: rs1 operand; signed for MULHSU.
REQ-009 Port b, input, XLEN: rs2 operand; unsigned for MULHSU.
REQ-010 Port out_valid, output, 1: result valid.
REQ-011 Port out_ready, input, 1: consumer accepts result.
REQ-012 Port result, output, XLEN: selected result.
REQ-013 Port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, MUL, DIV, DONE; one operation outstanding at a time.
REQ-015 in_ready = (state == IDLE); acceptance = in_valid && in_ready; a, b, funct3 are captured on acceptance and input changes afterwards are ignored.
REQ-016 Acceptance with funct3[2]=0: IDLE->MUL; after MUL_LATENCY-1 cycles in MUL, ->DONE; out_valid first high exactly MUL_LATENCY cycles after the acceptance edge.
REQ-017 Multiply arithmetic uses a 2*XLEN-bit product: MUL returns low XLEN bits; MULH high XLEN bits of signed x signed; MULHSU high bits of signed a x unsigned b; MULHU high bits of unsigned x unsigned.
REQ-018 Acceptance with funct3[2]=1, b != 0, and no signed overflow: IDLE->DIV; the unit runs a radix-2 restoring divider on magnitudes for XLEN iterations, applies sign fix-up, then ->DONE; out_valid first high XLEN+2 cycles after acceptance.
REQ-019 Divide by zero: DIV/DIVU result all ones; REM/REMU result = a; IDLE->DONE directly, so out_valid is high 1 cycle after acceptance.
REQ-020 Signed overflow (DIV/REM, a = most-negative value, b = all ones): DIV result = a; REM result = 0; out_valid is high 1 cycle after acceptance.
REQ-021 Signed remainder takes the sign of the dividend; signed quotient truncates toward zero.
REQ-022 DONE: out_valid=1 and result is held stable until out_valid && out_ready; then ->IDLE, and in_ready rises the following cycle (no same-cycle re-accept).
REQ-023 out_valid=0 and result=0 in every state other than DONE.
REQ-024 If out_ready is held low, the unit stays in DONE indefinitely with no change to result.

Reset
REQ-025 reset_n low at a rising edge forces state=IDLE, clears all datapath registers, iteration counter, and pipeline valid bits; this holds in any state, including mid-operation.
REQ-026 During and after reset: in_ready=1, out_valid=0, result=0, busy=0; an aborted operation never produces out_valid.

Configuration
REQ-027 Macro MULDIV_DIV_EN defined: divider, DIV state, and REQ-018..REQ-021 are present.
REQ-028 Macro MULDIV_DIV_EN undefined: no divider logic; funct3[2]=1 goes IDLE->DONE with result 0, out_valid 1 cycle after acceptance; multiply behaviour is unchanged.

Verification (XLEN=32, MUL_LATENCY=3, MULDIV_DIV_EN defined unless noted)
REQ-029 MULH a=0xFFFFFFFF, b=0x00000002 -> result 0xFFFFFFFF, out_valid 3 cycles after accept; MULHU with the same operands -> 0x00000001.
REQ-030 DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD after 34 cycles; REM with the same operands -> 0xFFFFFFFF.
REQ-031 DIVU a=5, b=0 -> 0xFFFFFFFF; REMU a=5, b=0 -> 0x00000005; DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; each has out_valid 1 cycle after accept.
REQ-032 MUL a=6, b=7 with out_ready low for 5 cycles -> result 0x2A held stable, in_ready=0 throughout, IDLE one cycle after handshake.
REQ-033 reset_n low at iteration 10 of a DIVU -> next cycle in_ready=1, out_valid=0, result=0; a following MUL 3x4 returns 0xC.
REQ-034 MULDIV_DIV_EN undefined: DIVU 10/2 -> result 0, out_valid 1 cycle after accept.
